// File: rtl/dbg_jtag_scan_master_if.sv
// Command/response bundle between a scan requester and the JTAG scan master.
// The requester owns the command fields; the scan master owns ready and the response.
interface dbg_jtag_scan_master_if #(
    parameter int DR_WIDTH = 38
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_is_ir;
    logic [5:0]          cmd_len;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_is_ir, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_is_ir, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/dbg_jtag_scan_master.sv
// System-clock JTAG scan initiator. It bit-bangs TCK/TMS/TDI towards a TAP,
// runs a Test-Logic-Reset sequence after reset, then serves IR/DR scan commands.
// Every TCK cycle is TCK_DIV clk low followed by TCK_DIV clk high.
// TMS/TDI change on the edge that drops TCK; TDO is sampled on the edge that raises it.
// After the last TCK of a sequence there is one extra busy clk
// (rsp_valid pulses there for scans); the block is back in RTI on the clk after that.
module dbg_jtag_scan_master #(
    parameter int IR_WIDTH   = 2,
    parameter int DR_WIDTH   = 38,
    parameter int TCK_DIV    = 4,
    parameter int RST_CYCLES = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    dbg_jtag_scan_master_if.slave   bus,
    output logic                    tck,
    output logic                    tms,
    output logic                    tdi,
    input  logic                    tdo,
    output logic                    busy
);
    // Per-state TCK usage:
    //   TLR_SEQ : RST_CYCLES pulses with TMS=1, then one with TMS=0
    //   SEL_DR  : RTI -> Select-DR (TMS=1)
    //   SEL_IR  : Select-DR -> Select-IR (TMS=1), IR scans only
    //   CAPTURE : two TMS=0 pulses, Select -> Capture -> Shift
    //   SHIFT   : one pulse per data bit, TMS=1 on the last one (-> Exit1)
    //   EXIT1   : Exit1 -> Update (TMS=1)
    //   UPDATE  : Update -> RTI (TMS=0)
    typedef enum logic [2:0] {
        TLR_SEQ, RTI, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);
    localparam logic [5:0] RST_LAST = 6'(RST_CYCLES);
    localparam logic [5:0] LEN_IR   = 6'(IR_WIDTH);
    localparam logic [5:0] LEN_DR   = 6'(DR_WIDTH);

    state_t              state, state_d;
    logic [7:0]          div_cnt, div_d;
    logic [5:0]          bit_cnt, bit_d;
    logic                tail, tail_d;
    logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                is_ir, is_ir_d;
    logic [5:0]          len_q, len_d;
    logic [DR_WIDTH-1:0] data_q, data_d;
    logic [DR_WIDTH-1:0] cap_q, cap_d;
    logic [5:0]          eff_len;
    logic                new_pulse;

    assign tck           = tck_q;
    assign tms           = tms_q;
    assign tdi           = tdi_q;
    assign busy          = (state != RTI);
    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // Clamp the requested length to the register width; zero means one bit.
    always_comb begin
        eff_len = bus.cmd_len;
        if (bus.cmd_len == 6'd0)
            eff_len = 6'd1;
        else if (bus.cmd_is_ir && (bus.cmd_len > LEN_IR))
            eff_len = LEN_IR;
        else if (!bus.cmd_is_ir && (bus.cmd_len > LEN_DR))
            eff_len = LEN_DR;
    end

    // Next-state and next-pin logic: command accept, TCK divider, TAP sequencing.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        state_d     = state;
        div_d       = div_cnt;
        bit_d       = bit_cnt;
        tail_d      = tail;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        is_ir_d     = is_ir;
        len_d       = len_q;
        data_d      = data_q;
        cap_d       = cap_q;
        new_pulse   = 1'b0;

        if (state == RTI) begin
            tck_d   = 1'b0;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            ready_d = 1'b1;
            if (bus.cmd_valid && ready_q) begin
                is_ir_d   = bus.cmd_is_ir;
                len_d     = eff_len;
                data_d    = bus.cmd_data;
                cap_d     = '0;
                ready_d   = 1'b0;
                state_d   = SEL_DR;
                bit_d     = 6'd0;
                div_d     = 8'd0;
                new_pulse = 1'b1;
            end
        end else if (tail) begin
            // Extra clk after the last TCK; next stop is RTI.
            tail_d  = 1'b0;
            state_d = RTI;
            ready_d = 1'b1;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
        end else if (div_cnt != DIV_LAST) begin
            div_d = div_cnt + 8'd1;
        end else begin
            div_d = 8'd0;
            if (!tck_q) begin
                // End of low half: raise TCK and sample TDO.
                tck_d = 1'b1;
                if (state == SHIFT)
                    cap_d[bit_cnt] = tdo;
            end else begin
                // End of high half: drop TCK and pick the next pulse.
                tck_d = 1'b0;
                unique case (state)
                    TLR_SEQ: begin
                        if (bit_cnt == RST_LAST) begin
                            tail_d = 1'b1;
                        end else begin
                            bit_d     = bit_cnt + 6'd1;
                            new_pulse = 1'b1;
                        end
                    end
                    SEL_DR: begin
                        state_d   = is_ir ? SEL_IR : CAPTURE;
                        bit_d     = 6'd0;
                        new_pulse = 1'b1;
                    end
                    SEL_IR: begin
                        state_d   = CAPTURE;
                        bit_d     = 6'd0;
                        new_pulse = 1'b1;
                    end
                    CAPTURE: begin
                        if (bit_cnt == 6'd1) begin
                            state_d = SHIFT;
                            bit_d   = 6'd0;
                        end else begin
                            bit_d   = 6'd1;
                        end
                        new_pulse = 1'b1;
                    end
                    SHIFT: begin
                        if (bit_cnt == len_q - 6'd1) begin
                            state_d = EXIT1;
                            bit_d   = 6'd0;
                        end else begin
                            bit_d   = bit_cnt + 6'd1;
                        end
                        new_pulse = 1'b1;
                    end
                    EXIT1: begin
                        state_d   = UPDATE;
                        new_pulse = 1'b1;
                    end
                    UPDATE: begin
                        tail_d      = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = cap_q;
                    end
                    default: ;
                endcase
            end
        end

        // Pin values for a pulse that starts on this edge.
        if (new_pulse) begin
            unique case (state_d)
                TLR_SEQ:               tms_d = (bit_d < RST_LAST);
                SEL_DR, SEL_IR, EXIT1: tms_d = 1'b1;
                SHIFT:                 tms_d = (bit_d == len_d - 6'd1);
                default:               tms_d = 1'b0;
            endcase
            tdi_d = (state_d == SHIFT) ? data_d[bit_d] : 1'b0;
        end
    end

    // State and output registers with synchronous reset into the TLR sequence.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values, regardless of statement order.
        if (reset) begin
            state       <= TLR_SEQ;
            div_cnt     <= 8'd0;
            bit_cnt     <= 6'd0;
            tail        <= 1'b0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            is_ir       <= 1'b0;
            len_q       <= 6'd1;
            data_q      <= '0;
            cap_q       <= '0;
        end else begin
            state       <= state_d;
            div_cnt     <= div_d;
            bit_cnt     <= bit_d;
            tail        <= tail_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            is_ir       <= is_ir_d;
            len_q       <= len_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
        end
    end
endmodule

// File: tb/tb_dbg_jtag_scan_master.sv
// Self-checking bench for dbg_jtag_scan_master with TCK_DIV=2: a table of scan
// vectors with hand-computed pulse counts, TMS patterns and responses, plus
// directed sequences for reset/TLR timing, held cmd_valid and mid-scan reset.
module tb_dbg_jtag_scan_master;
    localparam int IR_WIDTH   = 2;
    localparam int DR_WIDTH   = 38;
    localparam int TCK_DIV    = 2;
    localparam int RST_CYCLES = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tck, tms, tdi, tdo, busy;
    int   tdo_mode = 0;   // 0: loop tdi back, 1: tied high, 2: tied low

    always #5 clk = ~clk;

    assign tdo = (tdo_mode == 0) ? tdi : (tdo_mode == 1);

    dbg_jtag_scan_master_if #(.DR_WIDTH(DR_WIDTH)) bus ();

    dbg_jtag_scan_master #(
        .IR_WIDTH(IR_WIDTH), .DR_WIDTH(DR_WIDTH),
        .TCK_DIV(TCK_DIV), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pin monitor, sampled 1 time unit after each rising clk edge.
    int          n_pulse = 0;
    int          n_rsp = 0;
    int          n_bad_ready = 0;
    logic [63:0] tms_w = '0;
    logic [63:0] tdi_w = '0;
    logic        prev_tck = 1'b0;

    always @(posedge clk) begin
        #1;
        if (tck === 1'b1 && prev_tck === 1'b0) begin
            if (n_pulse < 64) begin
                tms_w[n_pulse] = tms;
                tdi_w[n_pulse] = tdi;
            end
            n_pulse++;
        end
        if (bus.rsp_valid === 1'b1) n_rsp++;
        if (bus.cmd_ready === 1'b1 && busy === 1'b1) n_bad_ready++;
        prev_tck = tck;
    end

    task automatic clear_mon();
        n_pulse = 0;
        n_rsp = 0;
        n_bad_ready = 0;
        tms_w = '0;
        tdi_w = '0;
    endtask

    // Apply reset, check reset values, release and check the TLR sequence.
    task automatic reset_and_tlr(input string tag);
        int cyc;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_rst_tck"}, tck, 1'b0);
        check({tag, "_rst_tms"}, tms, 1'b1);
        check({tag, "_rst_tdi"}, tdi, 1'b0);
        check({tag, "_rst_ready"}, bus.cmd_ready, 1'b0);
        check({tag, "_rst_rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, "_rst_rsp_data"}, bus.rsp_data, 38'h0);
        check({tag, "_rst_busy"}, busy, 1'b1);
        clear_mon();
        reset = 1'b0;
        cyc = 0;
        while (bus.cmd_ready !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_tlr_ready_latency"}, cyc, 25);
        check({tag, "_tlr_pulses"}, n_pulse, 6);
        check({tag, "_tlr_tms"}, tms_w, 64'h1F);
        check({tag, "_tlr_busy"}, busy, 1'b0);
    endtask

    // One command, waited on to completion; leaves the block idle in RTI.
    task automatic do_scan(input string tag, input logic ir, input logic [5:0] len,
                           input logic [DR_WIDTH-1:0] data);
        int cyc;
        clear_mon();
        cyc = 0;
        while (bus.cmd_ready !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ready_before"}, bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_is_ir = ir;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({tag, "_ready_drop"}, bus.cmd_ready, 1'b0);
        cyc = 0;
        while (n_rsp == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_rsp_seen"}, n_rsp, 1);
        check({tag, "_rsp_tck_low"}, tck, 1'b0);
        check({tag, "_rsp_busy"}, busy, 1'b1);
        @(negedge clk);
        check({tag, "_rti_ready"}, bus.cmd_ready, 1'b1);
        check({tag, "_rti_busy"}, busy, 1'b0);
        check({tag, "_rsp_one_clk"}, bus.rsp_valid, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic                ir;
        logic [5:0]          len;
        logic [DR_WIDTH-1:0] data;
        int                  tdo_mode;
        int                  exp_pulses;
        logic [63:0]         exp_tms;
        logic [DR_WIDTH-1:0] exp_rsp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          cyc;
        int          off;
        int          eff;
        logic [63:0] mask;
        logic [63:0] data64;

        bus.cmd_valid = 1'b0;
        bus.cmd_is_ir = 1'b0;
        bus.cmd_len   = 6'd0;
        bus.cmd_data  = '0;

        //           ir    len    data                tdo pulses tms pattern             response
        vecs[0] = '{1'b0, 6'd38, 38'h2A_5555_AAAA, 0, 43, 64'h0000_0300_0000_0001, 38'h2A_5555_AAAA};
        vecs[1] = '{1'b1, 6'd2,  38'h2,            1, 8,  64'h63,                  38'h3};
        vecs[2] = '{1'b0, 6'd0,  38'h3F_FFFF_FFFF, 0, 6,  64'h19,                  38'h1};
        vecs[3] = '{1'b0, 6'd50, 38'h15_0F0F_3C3C, 0, 43, 64'h0000_0300_0000_0001, 38'h15_0F0F_3C3C};
        vecs[4] = '{1'b1, 6'd5,  38'h1,            2, 8,  64'h63,                  38'h0};
        vecs[5] = '{1'b0, 6'd8,  38'h3F_0000_00A5, 1, 13, 64'hC01,                 38'hFF};
        vecs[6] = '{1'b1, 6'd1,  38'h1,            0, 7,  64'h33,                  38'h1};

        reset_and_tlr("init");

        for (int i = 0; i < 7; i++) begin
            tdo_mode = vecs[i].tdo_mode;
            do_scan($sformatf("v%0d", i), vecs[i].ir, vecs[i].len, vecs[i].data);
            check($sformatf("v%0d_pulses", i), n_pulse, vecs[i].exp_pulses);
            check($sformatf("v%0d_tms", i), tms_w, vecs[i].exp_tms);
            check($sformatf("v%0d_rsp_data", i), bus.rsp_data, vecs[i].exp_rsp);
            check($sformatf("v%0d_rsp_count", i), n_rsp, 1);
            check($sformatf("v%0d_ready_while_busy", i), n_bad_ready, 0);
            off    = vecs[i].ir ? 4 : 3;
            eff    = vecs[i].exp_pulses - 5 - (vecs[i].ir ? 1 : 0);
            mask   = (64'h1 << eff) - 64'h1;
            data64 = 64'(vecs[i].data);
            check($sformatf("v%0d_tdi_shift", i), (tdi_w >> off) & mask, data64 & mask);
        end

        // cmd_valid held across two scans: one accept per RTI visit, one idle clk between.
        tdo_mode = 0;
        clear_mon();
        bus.cmd_is_ir = 1'b0;
        bus.cmd_len   = 6'd4;
        bus.cmd_data  = 38'h9;
        bus.cmd_valid = 1'b1;
        cyc = 0;
        while (n_rsp == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("held_first_rsp", n_rsp, 1);
        check("held_first_pulses", n_pulse, 9);
        @(negedge clk);
        check("held_gap_busy", busy, 1'b0);
        check("held_gap_tck", tck, 1'b0);
        check("held_gap_ready", bus.cmd_ready, 1'b1);
        @(negedge clk);
        check("held_reaccept_busy", busy, 1'b1);
        check("held_reaccept_ready", bus.cmd_ready, 1'b0);
        cyc = 0;
        while (n_rsp < 2 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        check("held_second_rsp", n_rsp, 2);
        check("held_rsp_data", bus.rsp_data, 38'h9);
        repeat (3) @(negedge clk);
        check("held_idle_after", busy, 1'b0);
        check("held_total_pulses", n_pulse, 18);
        check("held_ready_while_busy", n_bad_ready, 0);

        // Reset in the middle of SHIFT bit 10 of a full DR scan.
        clear_mon();
        bus.cmd_is_ir = 1'b0;
        bus.cmd_len   = 6'd38;
        bus.cmd_data  = 38'h2A_5555_AAAA;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        cyc = 0;
        while (n_pulse < 14 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_at_bit10", n_pulse, 14);
        check("abort_tck_high", tck, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_tck", tck, 1'b0);
        check("abort_tms", tms, 1'b1);
        check("abort_busy", busy, 1'b1);
        check("abort_no_rsp", n_rsp, 0);
        reset_and_tlr("abort");
        repeat (10) @(negedge clk);
        check("abort_no_late_rsp", n_rsp, 0);

        // One normal scan after the aborted one.
        tdo_mode = 1;
        do_scan("post", 1'b0, 6'd3, 38'h5);
        check("post_pulses", n_pulse, 8);
        check("post_rsp_data", bus.rsp_data, 38'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end
endmodule
